// File: rtl/avg_threshold_detector.sv
// Debounced hysteresis comparator on the moving-average output: alarm level, rise/fall
// pulses, per-episode peak capture and a saturating episode counter.
module avg_threshold_detector #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DEBOUNCE = 3,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] Z,
    input  logic [WIDTH-1:0] th_hi,
    input  logic [WIDTH-1:0] th_lo,
    output logic             alarm,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [WIDTH-1:0] peak,
    output logic [CNT_W-1:0] event_count,
    output logic             cfg_err
);

    typedef enum logic [1:0] {StBelow, StRising, StAbove, StFalling} state_t;

    localparam logic [4:0] DebLast = 5'(DEBOUNCE);
    localparam bit         DebOne  = (DEBOUNCE == 1);

    state_t           state;
    logic [3:0]       deb;
    logic             hi_q;
    logic             lo_q;
    logic [4:0]       deb_next;
    logic             deb_done;
    logic [WIDTH-1:0] peak_max;
    logic [CNT_W-1:0] count_inc;

    always_comb begin
        hi_q      = (Z >= th_hi);
        lo_q      = (Z <= th_lo);
        deb_next  = {1'b0, deb} + 5'd1;
        deb_done  = (deb_next == DebLast);
        peak_max  = (Z > peak) ? Z : peak;
        count_inc = (event_count == {CNT_W{1'b1}}) ? event_count
                                                   : event_count + CNT_W'(1);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= StBelow;
            deb         <= 4'd0;
            alarm       <= 1'b0;
            rise_pulse  <= 1'b0;
            fall_pulse  <= 1'b0;
            peak        <= '0;
            event_count <= '0;
            cfg_err     <= 1'b0;
        end else begin
            cfg_err    <= (th_lo >= th_hi);
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            if (enable) begin
                case (state)
                    StBelow, StRising: begin
                        if (hi_q && (DebOne || (state == StRising && deb_done))) begin
                            // New episode: peak restarts from the qualifying sample
                            state       <= StAbove;
                            deb         <= 4'd0;
                            alarm       <= 1'b1;
                            rise_pulse  <= 1'b1;
                            peak        <= Z;
                            event_count <= count_inc;
                        end else if (hi_q) begin
                            state <= StRising;
                            deb   <= (state == StRising) ? deb_next[3:0] : 4'd1;
                        end else begin
                            state <= StBelow;
                            deb   <= 4'd0;
                        end
                    end
                    StAbove, StFalling: begin
                        // The exit sample still counts toward the episode peak
                        peak <= peak_max;
                        if (lo_q && (DebOne || (state == StFalling && deb_done))) begin
                            state      <= StBelow;
                            deb        <= 4'd0;
                            alarm      <= 1'b0;
                            fall_pulse <= 1'b1;
                        end else if (lo_q) begin
                            state <= StFalling;
                            deb   <= (state == StFalling) ? deb_next[3:0] : 4'd1;
                        end else begin
                            state <= StAbove;
                            deb   <= 4'd0;
                        end
                    end
                    default: begin
                        state <= StBelow;
                        deb   <= 4'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_avg_threshold_detector.sv
// Scoreboard bench: stimulus pushes hand-computed expectations, a negedge monitor pops and
// compares them against a default instance and a CNT_W=2 instance sharing the same inputs.
module tb_avg_threshold_detector;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       enable;
    logic [7:0] Z;
    logic [7:0] th_hi;
    logic [7:0] th_lo;

    logic       alarm, rise_pulse, fall_pulse, cfg_err;
    logic [7:0] peak, event_count;
    logic       s_alarm, s_rise, s_fall, s_cfg;
    logic [7:0] s_peak;
    logic [1:0] s_count;

    typedef struct {
        int         idx;
        logic       alarm;
        logic       rise;
        logic       fall;
        logic [7:0] peak;
        logic [7:0] count;
        logic       cfg;
        logic [1:0] sat;
    } exp_t;

    exp_t q[$];
    int   tests  = 0;
    int   failed = 0;
    int   nstep  = 0;

    avg_threshold_detector #(.WIDTH(8), .DEBOUNCE(3), .CNT_W(8)) dut (
        .Clk(Clk), .Reset(Reset), .enable(enable), .Z(Z), .th_hi(th_hi), .th_lo(th_lo),
        .alarm(alarm), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .peak(peak),
        .event_count(event_count), .cfg_err(cfg_err)
    );

    avg_threshold_detector #(.WIDTH(8), .DEBOUNCE(3), .CNT_W(2)) dut_sat (
        .Clk(Clk), .Reset(Reset), .enable(enable), .Z(Z), .th_hi(th_hi), .th_lo(th_lo),
        .alarm(s_alarm), .rise_pulse(s_rise), .fall_pulse(s_fall), .peak(s_peak),
        .event_count(s_count), .cfg_err(s_cfg)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s step %0d: got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    always @(negedge Clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check("alarm", e.idx, 32'(alarm), 32'(e.alarm));
            check("rise_pulse", e.idx, 32'(rise_pulse), 32'(e.rise));
            check("fall_pulse", e.idx, 32'(fall_pulse), 32'(e.fall));
            check("peak", e.idx, 32'(peak), 32'(e.peak));
            check("event_count", e.idx, 32'(event_count), 32'(e.count));
            check("cfg_err", e.idx, 32'(cfg_err), 32'(e.cfg));
            check("sat_alarm", e.idx, 32'(s_alarm), 32'(e.alarm));
            check("sat_event_count", e.idx, 32'(s_count), 32'(e.sat));
        end
    end

    // Drive one cycle, then queue what the outputs must show after that edge.
    task automatic step(input logic r, input logic en, input logic [7:0] z, input logic a,
                        input logic rp, input logic fp, input logic [7:0] pk,
                        input logic [7:0] cnt, input logic cfg);
        exp_t e;
        Reset  = r;
        enable = en;
        Z      = z;
        @(posedge Clk);
        #1;
        e.idx   = nstep;
        e.alarm = a;
        e.rise  = rp;
        e.fall  = fp;
        e.peak  = pk;
        e.count = cnt;
        e.cfg   = cfg;
        e.sat   = (cnt > 8'd3) ? 2'd3 : cnt[1:0];
        q.push_back(e);
        nstep++;
    endtask

    initial begin
        logic [7:0] prev_pk;
        th_hi = 8'd100;
        th_lo = 8'd60;
        // Reset dominates enable with Z=255
        step(1, 1, 255, 0, 0, 0, 0, 0, 0);
        step(1, 1, 255, 0, 0, 0, 0, 0, 0);
        // Debounced rise
        step(0, 1, 120, 0, 0, 0, 0, 0, 0);
        step(0, 1, 120, 0, 0, 0, 0, 0, 0);
        step(0, 1, 120, 1, 1, 0, 120, 1, 0);
        step(0, 0, 0,   1, 0, 0, 120, 1, 0);
        // Hysteresis: 80 holds, 70 resets fall debounce
        step(0, 1, 150, 1, 0, 0, 150, 1, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 80, 1, 0, 0, 150, 1, 0);
        step(0, 1, 60, 1, 0, 0, 150, 1, 0);
        step(0, 1, 70, 1, 0, 0, 150, 1, 0);
        step(0, 1, 60, 1, 0, 0, 150, 1, 0);
        step(0, 1, 60, 1, 0, 0, 150, 1, 0);
        step(0, 1, 60, 0, 0, 1, 150, 1, 0);
        step(0, 0, 0,  0, 0, 0, 150, 1, 0);
        // Glitch rejection, then clean rise replacing the old peak
        step(0, 1, 120, 0, 0, 0, 150, 1, 0);
        step(0, 1, 120, 0, 0, 0, 150, 1, 0);
        step(0, 1, 50,  0, 0, 0, 150, 1, 0);
        step(0, 1, 120, 0, 0, 0, 150, 1, 0);
        step(0, 1, 120, 0, 0, 0, 150, 1, 0);
        step(0, 1, 120, 1, 1, 0, 120, 2, 0);
        step(0, 1, 60,  1, 0, 0, 120, 2, 0);
        step(0, 1, 60,  1, 0, 0, 120, 2, 0);
        step(0, 1, 60,  0, 0, 1, 120, 2, 0);
        // Enable gaps are ignored
        step(0, 1, 120, 0, 0, 0, 120, 2, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0, 120, 2, 0);
        step(0, 1, 120, 0, 0, 0, 120, 2, 0);
        step(0, 1, 120, 1, 1, 0, 120, 3, 0);
        step(0, 1, 60,  1, 0, 0, 120, 3, 0);
        step(0, 1, 60,  1, 0, 0, 120, 3, 0);
        step(0, 1, 60,  0, 0, 1, 120, 3, 0);
        // Reset mid-RISING discards partial debounce
        step(0, 1, 120, 0, 0, 0, 120, 3, 0);
        step(0, 1, 120, 0, 0, 0, 120, 3, 0);
        step(1, 1, 120, 0, 0, 0, 0, 0, 0);
        step(0, 1, 120, 0, 0, 0, 0, 0, 0);
        step(0, 1, 120, 0, 0, 0, 0, 0, 0);
        step(0, 1, 120, 1, 1, 0, 120, 1, 0);
        step(0, 1, 60,  1, 0, 0, 120, 1, 0);
        step(0, 1, 60,  1, 0, 0, 120, 1, 0);
        step(0, 1, 60,  0, 0, 1, 120, 1, 0);
        // Four more episodes: 5 total since reset, 2-bit counter pins at 3
        prev_pk = 8'd120;
        for (int e = 2; e <= 5; e++) begin
            step(0, 1, 200, 0, 0, 0, prev_pk, 8'(e - 1), 0);
            step(0, 1, 200, 0, 0, 0, prev_pk, 8'(e - 1), 0);
            step(0, 1, 200, 1, 1, 0, 200, 8'(e), 0);
            step(0, 1, 60,  1, 0, 0, 200, 8'(e), 0);
            step(0, 1, 60,  1, 0, 0, 200, 8'(e), 0);
            step(0, 1, 60,  0, 0, 1, 200, 8'(e), 0);
            prev_pk = 8'd200;
        end
        // Reset while ABOVE drops alarm without a fall pulse
        step(0, 1, 120, 0, 0, 0, 200, 5, 0);
        step(0, 1, 120, 0, 0, 0, 200, 5, 0);
        step(0, 1, 120, 1, 1, 0, 120, 6, 0);
        step(1, 1, 120, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0,   0, 0, 0, 0, 0, 0);
        // cfg_err follows thresholds even with enable low
        th_lo = 8'd100;
        th_hi = 8'd100;
        step(0, 0, 0,   0, 0, 0, 0, 0, 1);
        step(0, 1, 100, 0, 0, 0, 0, 0, 1);
        th_lo = 8'd99;
        step(0, 0, 0,   0, 0, 0, 0, 0, 0);
        th_lo = 8'd101;
        step(0, 0, 0,   0, 0, 0, 0, 0, 1);

        repeat (2) @(negedge Clk);
        #1;
        tests++;
        if (q.size() != 0) begin
            failed++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
